// File: rtl/bar_position_scheduler.sv
// Raster bar position scheduler: slow tick, key-steered Y, sweeping X, with
// shadow registers committed to the visible outputs only at frame start.
module bar_position_scheduler #(
   parameter int screen_width  = 640,
   parameter int screen_height = 480,
   parameter int w_key         = 4,
   parameter int tick_log2     = 20,
   parameter int w_x           = $clog2(screen_width),
   parameter int w_y           = $clog2(screen_height)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [w_key-1:0] key,
   input  logic             run,
   input  logic             frame_start,
   output logic [w_x-1:0]   x_pos,
   output logic [w_y-1:0]   y_pos,
   output logic             updated,
   output logic [7:0]       dropped
);

   localparam logic [w_x-1:0] x_last = w_x'(screen_width - 1);
   localparam logic [w_y-1:0] y_last = w_y'(screen_height - 1);
   localparam logic [w_y-1:0] y_home = w_y'(screen_height / 2);

   typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

   state_t               state;
   state_t               state_next;
   logic                 drop_inc;
   logic [tick_log2-1:0] prescaler;
   logic                 tick;
   logic [w_key-1:0]     ks1;
   logic [w_key-1:0]     ks2;
   logic                 up;
   logic                 dn;
   logic [w_x-1:0]       sx;
   logic [w_y-1:0]       sy;

   assign tick = (prescaler == '0);
   assign up   = ks2[0];
   assign dn   = |ks2[w_key-1:1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler <= '0;
         ks1       <= '0;
         ks2       <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
         ks1       <= key;
         ks2       <= ks1;
      end
   end

   // Shadow positions advance on every tick, regardless of commit state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sx <= '0;
         sy <= y_home;
      end else if (tick) begin
         if (run)
            sx <= (sx == x_last) ? '0 : sx + 1'b1;
         if (sy == '0 || sy == y_last)
            sy <= y_home;
         else if (up && !dn)
            sy <= sy + 1'b1;
         else if (dn && !up)
            sy <= sy - 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      drop_inc   = 1'b0;
      unique case (state)
         IDLE:
            if (tick)
               state_next = PENDING;
         PENDING:
            if (frame_start)
               state_next = COMMIT;
            else if (tick)
               drop_inc = 1'b1;
         COMMIT:
            state_next = tick ? PENDING : IDLE;
         default:
            state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // COMMIT copies the shadows as they stood before any tick in this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_pos   <= '0;
         y_pos   <= y_home;
         updated <= 1'b0;
         dropped <= '0;
      end else begin
         updated <= (state == COMMIT);
         if (state == COMMIT) begin
            x_pos <= sx;
            y_pos <= sy;
         end
         if (drop_inc && dropped != 8'hFF)
            dropped <= dropped + 1'b1;
      end
   end

endmodule

// File: tb/tb_bar_position_scheduler.sv
// Randomised and directed bench for bar_position_scheduler, checked every cycle
// against a frame-level behavioural model of bar positions and commits.
module tb_bar_position_scheduler;

   localparam int sw = 640;
   localparam int sh = 480;
   localparam int tick_period = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key = '0;
   logic       run = 1'b0;
   logic       frame_start = 1'b0;
   logic [9:0] x_pos;
   logic [8:0] y_pos;
   logic       updated;
   logic [7:0] dropped;

   int checks = 0;
   int failures = 0;

   int         cyc;
   int         sx, sy, mx, my, m_drop, m_upd;
   bit         m_wait, m_commit;
   logic [3:0] key_d1, key_d2;

   bar_position_scheduler #(
      .screen_width(sw), .screen_height(sh), .w_key(4), .tick_log2(4)
   ) dut (
      .clk(clk), .rst(rst), .key(key), .run(run), .frame_start(frame_start),
      .x_pos(x_pos), .y_pos(y_pos), .updated(updated), .dropped(dropped)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("x_pos", int'(x_pos), mx);
      checkOutput("y_pos", int'(y_pos), my);
      checkOutput("updated", int'(updated), m_upd);
      checkOutput("dropped", int'(dropped), m_drop);
   endtask

   task automatic modelReset();
      cyc = 0;
      sx = 0; sy = sh / 2;
      mx = 0; my = sh / 2;
      m_upd = 0; m_drop = 0;
      m_wait = 1'b0; m_commit = 1'b0;
      key_d1 = '0; key_d2 = '0;
   endtask

   // One clock edge of intended behaviour; keys are seen two edges late.
   task automatic modelEdge(input logic [3:0] k, input logic r, input logic f);
      bit tick, up, dn;
      tick = (cyc % tick_period) == 0;
      cyc++;
      up = key_d2[0];
      dn = |key_d2[3:1];
      if (m_commit) begin
         mx = sx; my = sy; m_upd = 1;
      end else begin
         m_upd = 0;
      end
      if (m_commit) begin
         m_commit = 1'b0;
         m_wait = tick;
      end else if (m_wait) begin
         if (f) begin
            m_commit = 1'b1;
            m_wait = 1'b0;
         end else if (tick && m_drop < 255) begin
            m_drop++;
         end
      end else if (tick) begin
         m_wait = 1'b1;
      end
      if (tick) begin
         if (r) sx = (sx + 1) % sw;
         if (sy == 0 || sy == sh - 1) sy = sh / 2;
         else if (up && !dn) sy = sy + 1;
         else if (dn && !up) sy = sy - 1;
      end
      key_d2 = key_d1;
      key_d1 = k;
   endtask

   task automatic applyStimulus(input logic [3:0] k, input logic r, input logic f);
      key = k; run = r; frame_start = f;
      @(posedge clk);
      modelEdge(k, r, f);
      #1;
      checkAll();
   endtask

   task automatic commitRound(input logic [3:0] k, input logic r);
      repeat (tick_period) applyStimulus(k, r, 1'b0);
      applyStimulus(k, r, 1'b1);
      repeat (3) applyStimulus(k, r, 1'b0);
   endtask

   task automatic resetMid();
      #3 rst = 1'b1;
      #1 modelReset();
      checkAll();
      #3 rst = 1'b0;
   endtask

   initial begin
      logic [3:0] rk;
      logic       rr;
      modelReset();
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      #1 checkAll();

      repeat (3) commitRound(4'b0001, 1'b1);
      repeat (3) commitRound(4'b0011, 1'b1);

      // Long stretch without frame_start: saturation, X wrap, Y reload.
      repeat (700 * tick_period) applyStimulus(4'b0001, 1'b1, 1'b0);
      applyStimulus(4'b0001, 1'b1, 1'b1);
      repeat (4) applyStimulus(4'b0001, 1'b1, 1'b0);

      repeat (260 * tick_period) applyStimulus(4'b0100, 1'b1, 1'b0);
      commitRound(4'b0100, 1'b1);

      repeat (3) commitRound(4'b0000, 1'b0);
      repeat (2) commitRound(4'b0001, 1'b0);

      rk = 4'b0001;
      rr = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) rk = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) == 0) rr = ~rr;
         applyStimulus(rk, rr, $urandom_range(0, 19) == 0);
      end

      repeat (20) applyStimulus(4'b0001, 1'b1, 1'b0);
      resetMid();
      applyStimulus(4'b0001, 1'b1, 1'b1);
      repeat (4) applyStimulus(4'b0001, 1'b1, 1'b0);
      repeat (2) commitRound(4'b0001, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
